foodfight_rom_loader: RTL and testbench
=======================================

FOODFIGHT_ROM_LOADER -- requirements
Module: foodfight_rom_loader

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning; clock and reset are listed first.
REQ-002 clk  input  1  single system clock; all logic is on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dl_en  input  1  download window; stays high for the whole image transfer.
REQ-005 dl_wr  input  1  byte strobe, one cycle per byte; valid only while dl_en=1.
REQ-006 dl_addr  input  16  byte address within the downloaded image.
REQ-007 dl_data  input  8  byte value.
REQ-008 rom_a  output  13  write address into the code ROM bank.
REQ-009 rom_d  output  8  write data.
REQ-010 rom_we  output  4  one-hot write enable; bit n selects code bank n (8 KB each, 32 KB total).
REQ-011 cpu_hold  output  1  holds the CPU in reset while no complete image is loaded.
REQ-012 load_done  output  1  a complete image has been loaded.
REQ-013 short_load  output  1  the last download ended with fewer than 32768 bytes accepted.
REQ-014 addr_ovf  output  1  the last download contained a byte with dl_addr >= 0x8000.

Function
REQ-015 The state machine SHALL have three states: IDLE, LOADING and DONE.
REQ-016 From IDLE or DONE, dl_en=1 SHALL move the state to LOADING on the next edge.
REQ-017 On entry to LOADING, the byte counter, short_load and addr_ovf SHALL clear.
REQ-018 From LOADING, dl_en=0 SHALL move the state to DONE on the next edge.
REQ-019 On the LOADING-to-DONE transition, short_load SHALL be set if the counter is below 32768.
REQ-020 A byte SHALL be accepted when dl_en=1, dl_wr=1 and dl_addr < 0x8000, in any state, including the first dl_en cycle.
REQ-021 For an accepted byte, on the next edge: rom_a=dl_addr[12:0], rom_d=dl_data, rom_we bit dl_addr[14:13] =1; latency is 1 cycle.
REQ-022 rom_we SHALL be high for exactly one cycle per accepted byte; back-to-back strobes on consecutive cycles SHALL each produce a pulse.
REQ-023 rom_a and rom_d SHALL hold their values between accepted bytes.
REQ-024 A byte with dl_addr >= 0x8000 SHALL produce no rom_we pulse, SHALL set addr_ovf, and SHALL not be counted.
REQ-025 dl_wr while dl_en=0 SHALL be ignored.
REQ-026 The byte counter SHALL be 16 bits and saturate at 0xFFFF; duplicate addresses count each time.
REQ-027 cpu_hold SHALL be 1 in IDLE and LOADING.
REQ-028 In DONE, cpu_hold SHALL be 1 if short_load=1, otherwise 0.
REQ-029 load_done SHALL be 1 only in DONE with short_load=0.
REQ-030 When dl_en and dl_wr are both high on the final cycle of the window, that byte SHALL be accepted and counted before the short_load evaluation.

Reset
REQ-031 Reset SHALL force the state to IDLE and set rom_we=0, rom_a=0, rom_d=0, cpu_hold=1, load_done=0, short_load=0, addr_ovf=0, and counter=0.
REQ-032 Reset asserted mid-download SHALL suppress any pending rom_we pulse on the same edge.
REQ-033 After reset during a download, the block SHALL wait in IDLE until dl_en is seen high, then start a fresh LOADING.

Configuration
REQ-034 With ROM_CHECKSUM_EN defined, the block SHALL add output cksum (4x8 bits, bank-major): a per-bank 8-bit modulo-256 sum of accepted bytes.
REQ-035 With ROM_CHECKSUM_EN defined, cksum SHALL clear on LOADING entry and on reset, and SHALL update on the same edge as rom_we.
REQ-036 Without ROM_CHECKSUM_EN, the cksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then 32768 bytes with data=addr[7:0] at one per cycle, then dl_en low: expect 32768 single-cycle rom_we pulses, bank = addr[14:13], load_done=1, cpu_hold=0, short_load=0.
REQ-038 Write addr 0x2001 data 0x5A: expect rom_we=4'b0010, rom_a=0x0001, rom_d=0x5A exactly one cycle after dl_wr.
REQ-039 Download of 100 bytes: expect DONE with short_load=1, cpu_hold=1, load_done=0.
REQ-040 Write addr 0x8000 mid-stream: expect no rom_we pulse, addr_ovf=1, count unchanged.
REQ-041 Reset asserted mid-stream, then a full reload: expect no pulse on the reset edge, cpu_hold=1 throughout, and a clean DONE at the end.
REQ-042 With ROM_CHECKSUM_EN: bank 3 filled with 0x01 gives cksum bank 3 = 0x00 (8192 mod 256), and bank 0 with a single 0xFF byte gives 0xFF.

Source files
------------

// File: rtl/foodfight_rom_loader.sv
// Streams a downloaded 32 KB code image into four 8 KB ROM banks and holds the CPU until complete.
// Optional per-bank checksum output enabled with `define ROM_CHECKSUM_EN.
module foodfight_rom_loader (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dl_en,
  input  logic        i_dl_wr,
  input  logic [15:0] i_dl_addr,
  input  logic [7:0]  i_dl_data,
  output logic [12:0] o_rom_a,
  output logic [7:0]  o_rom_d,
  output logic [3:0]  o_rom_we,
  output logic        o_cpu_hold,
  output logic        o_load_done,
  output logic        o_short_load,
  output logic        o_addr_ovf
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [3:0][7:0] o_cksum
`endif
);

  typedef enum logic [1:0] {StIdle, StLoading, StDone} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [12:0] r_rom_a;
  logic [7:0]  r_rom_d;
  logic [3:0]  r_rom_we;
  logic [15:0] r_cnt;
  logic        r_short;
  logic        r_ovf;
  logic        w_accept;
  logic        w_bad;
  logic        w_enter;
  logic        w_finish;
  logic [1:0]  w_bank;

  assign w_bank   = i_dl_addr[14:13];
  assign w_accept = i_dl_en & i_dl_wr & ~i_dl_addr[15];
  assign w_bad    = i_dl_en & i_dl_wr & i_dl_addr[15];

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_finish    = 1'b0;
    o_cpu_hold  = 1'b1;
    o_load_done = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_dl_en) begin
          w_state_nxt = StLoading;
          w_enter     = 1'b1;
        end
      end
      StLoading: begin
        if (!i_dl_en) begin
          w_state_nxt = StDone;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (r_state == StDone) begin
      o_cpu_hold  = r_short;
      o_load_done = ~r_short;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_rom_a  <= '0;
      r_rom_d  <= '0;
      r_rom_we <= '0;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rom_we <= '0;
      if (w_accept) begin
        r_rom_a  <= i_dl_addr[12:0];
        r_rom_d  <= i_dl_data;
        r_rom_we <= 4'b0001 << w_bank;
      end
      // A byte on the window's opening cycle belongs to the new load, so it survives the clear.
      if (w_enter) begin
        r_cnt <= {15'b0, w_accept};
      end else if (w_accept && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_enter) begin
        r_ovf <= w_bad;
      end else if (w_bad) begin
        r_ovf <= 1'b1;
      end
      if (w_enter) begin
        r_short <= 1'b0;
      end else if (w_finish) begin
        r_short <= ~r_cnt[15];
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [3:0][7:0] r_cksum;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cksum <= '0;
    end else if (w_enter) begin
      r_cksum <= '0;
      if (w_accept) begin
        r_cksum[w_bank] <= i_dl_data;
      end
    end else if (w_accept) begin
      r_cksum[w_bank] <= r_cksum[w_bank] + i_dl_data;
    end
  end

  assign o_cksum = r_cksum;
`endif

  assign o_rom_a      = r_rom_a;
  assign o_rom_d      = r_rom_d;
  assign o_rom_we     = r_rom_we;
  assign o_short_load = r_short;
  assign o_addr_ovf   = r_ovf;

endmodule

// File: tb/tb_foodfight_rom_loader.sv
// Directed self-checking bench for foodfight_rom_loader; checksum checks run when ROM_CHECKSUM_EN is defined.
module tb_foodfight_rom_loader;

  logic        clk;
  logic        reset;
  logic        dl_en;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic [12:0] rom_a;
  logic [7:0]  rom_d;
  logic [3:0]  rom_we;
  logic        cpu_hold;
  logic        load_done;
  logic        short_load;
  logic        addr_ovf;
`ifdef ROM_CHECKSUM_EN
  logic [3:0][7:0] cksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  foodfight_rom_loader u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_dl_en      (dl_en),
    .i_dl_wr      (dl_wr),
    .i_dl_addr    (dl_addr),
    .i_dl_data    (dl_data),
    .o_rom_a      (rom_a),
    .o_rom_d      (rom_d),
    .o_rom_we     (rom_we),
    .o_cpu_hold   (cpu_hold),
    .o_load_done  (load_done),
    .o_short_load (short_load),
    .o_addr_ovf   (addr_ovf)
`ifdef ROM_CHECKSUM_EN
    ,
    .o_cksum      (cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of a streamed byte and scores the resulting ROM write.
  task automatic stream_byte(input logic [15:0] a, input logic [7:0] d, inout int good,
                             inout int hold_bad);
    logic [3:0] exp_we;
    exp_we  = 4'b0001 << a[14:13];
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    step();
    if (rom_we === exp_we && rom_a === a[12:0] && rom_d === d) good++;
    if (cpu_hold !== 1'b1) hold_bad++;
  endtask

  initial begin
    int good;
    int hold_bad;
    reset   = 1'b1;
    dl_en   = 1'b0;
    dl_wr   = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    step();
    step();
    check_eq("rst_we",    32'(rom_we), 32'h0);
    check_eq("rst_a",     32'(rom_a), 32'h0);
    check_eq("rst_d",     32'(rom_d), 32'h0);
    check_eq("rst_hold",  32'(cpu_hold), 32'h1);
    check_eq("rst_done",  32'(load_done), 32'h0);
    check_eq("rst_short", 32'(short_load), 32'h0);
    check_eq("rst_ovf",   32'(addr_ovf), 32'h0);
    reset = 1'b0;
    step();
    check_eq("idle_hold", 32'(cpu_hold), 32'h1);

    // Single write on the opening cycle of a window, then a 100-byte short load.
    dl_en   = 1'b1;
    dl_wr   = 1'b1;
    dl_addr = 16'h2001;
    dl_data = 8'h5A;
    step();
    check_eq("w2001_we", 32'(rom_we), 32'h2);
    check_eq("w2001_a",  32'(rom_a), 32'h0001);
    check_eq("w2001_d",  32'(rom_d), 32'h5A);
    dl_wr = 1'b0;
    step();
    check_eq("w2001_we_off", 32'(rom_we), 32'h0);
    check_eq("w2001_a_hold", 32'(rom_a), 32'h0001);
    check_eq("w2001_d_hold", 32'(rom_d), 32'h5A);
    good = 0;
    hold_bad = 0;
    for (int i = 0; i < 99; i++) stream_byte(16'h0100 + 16'(i), 8'(i), good, hold_bad);
    check_eq("short_pulses", 32'(good), 32'd99);
    dl_wr = 1'b0;
    dl_en = 1'b0;
    step();
    check_eq("short_short", 32'(short_load), 32'h1);
    check_eq("short_hold",  32'(cpu_hold), 32'h1);
    check_eq("short_done",  32'(load_done), 32'h0);
    check_eq("short_ovf",   32'(addr_ovf), 32'h0);
    check_eq("short_a",     32'(rom_a), 32'h0162);

    // Strobe outside the window is ignored.
    dl_wr   = 1'b1;
    dl_addr = 16'h0010;
    dl_data = 8'h33;
    step();
    check_eq("noen_we", 32'(rom_we), 32'h0);
    check_eq("noen_d",  32'(rom_d), 32'h62);
    dl_wr = 1'b0;

    // 32767 valid bytes plus one out-of-range byte: must stay one short of complete.
    dl_en = 1'b1;
    good = 0;
    hold_bad = 0;
    for (int j = 0; j < 32768; j++) begin
      if (j == 1000) begin
        dl_wr   = 1'b1;
        dl_addr = 16'h8000;
        dl_data = 8'hEE;
        step();
        check_eq("ovf_no_we", 32'(rom_we), 32'h0);
        check_eq("ovf_flag",  32'(addr_ovf), 32'h1);
        check_eq("ovf_a_hold", 32'(rom_a), 32'd999);
      end else begin
        stream_byte(16'(j < 1000 ? j : j - 1), 8'(j < 1000 ? j : j - 1), good, hold_bad);
      end
    end
    check_eq("ovf_pulses", 32'(good), 32'd32767);
    dl_wr = 1'b0;
    dl_en = 1'b0;
    step();
    check_eq("ovf_short", 32'(short_load), 32'h1);
    check_eq("ovf_end",   32'(addr_ovf), 32'h1);
    check_eq("ovf_done",  32'(load_done), 32'h0);
    check_eq("ovf_hold",  32'(cpu_hold), 32'h1);

    // Reset in mid-stream, then a full clean reload.
    dl_en = 1'b1;
    good = 0;
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      stream_byte(16'(i), 8'(i), good, hold_bad);
      if (i == 0) check_eq("ovf_clr_entry", 32'(addr_ovf), 32'h0);
    end
    dl_wr   = 1'b1;
    dl_addr = 16'h0040;
    dl_data = 8'h77;
    reset   = 1'b1;
    step();
    check_eq("mrst_we",   32'(rom_we), 32'h0);
    check_eq("mrst_a",    32'(rom_a), 32'h0);
    check_eq("mrst_hold", 32'(cpu_hold), 32'h1);
    reset = 1'b0;
    good = 0;
    hold_bad = 0;
    for (int j = 0; j < 32768; j++) stream_byte(16'(j), 8'(j), good, hold_bad);
    check_eq("full_pulses",   32'(good), 32'd32768);
    check_eq("full_hold_bad", 32'(hold_bad), 32'd0);
    dl_wr = 1'b0;
    dl_en = 1'b0;
    step();
    check_eq("full_we",    32'(rom_we), 32'h0);
    check_eq("full_done",  32'(load_done), 32'h1);
    check_eq("full_hold",  32'(cpu_hold), 32'h0);
    check_eq("full_short", 32'(short_load), 32'h0);
    check_eq("full_ovf",   32'(addr_ovf), 32'h0);
    check_eq("full_a",     32'(rom_a), 32'h1FFF);
    check_eq("full_d",     32'(rom_d), 32'hFF);

`ifdef ROM_CHECKSUM_EN
    // Bank 0 gets a single 0xFF on the opening cycle; bank 3 is filled with 0x01.
    dl_en = 1'b1;
    good = 0;
    hold_bad = 0;
    stream_byte(16'h0000, 8'hFF, good, hold_bad);
    check_eq("ck_entry_b0", 32'(cksum[0]), 32'hFF);
    check_eq("ck_entry_b1", 32'(cksum[1]), 32'h00);
    for (int k = 0; k < 8192; k++) begin
      stream_byte(16'h6000 + 16'(k), 8'h01, good, hold_bad);
      if (k == 0) check_eq("ck_b3_first", 32'(cksum[3]), 32'h01);
    end
    dl_wr = 1'b0;
    dl_en = 1'b0;
    step();
    check_eq("ck_b0", 32'(cksum[0]), 32'hFF);
    check_eq("ck_b1", 32'(cksum[1]), 32'h00);
    check_eq("ck_b2", 32'(cksum[2]), 32'h00);
    check_eq("ck_b3", 32'(cksum[3]), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
